// File: rtl/mem_access_controller_if.sv
// Bundles the EX/MEM-side access signals and the data-memory req/ack bus
// so the controller and its environment share one connection point.
interface mem_access_controller_if;
  logic        EX_MEM_MemRead;
  logic        EX_MEM_MemWrite;
  logic [31:0] EX_MEM_ALUResult;
  logic [31:0] EX_MEM_RtData;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] MemReadData;
  logic        stall;
  logic        mem_fault;
  logic        done;

  modport master (
    input  EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_ALUResult, EX_MEM_RtData,
    input  mem_ack, mem_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output MemReadData, stall, mem_fault, done
  );

  modport slave (
    output EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_ALUResult, EX_MEM_RtData,
    output mem_ack, mem_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  MemReadData, stall, mem_fault, done
  );
endinterface

// File: rtl/mem_access_controller.sv
// Sequences one EX/MEM load/store at a time onto a req/ack data memory,
// stalling the pipeline until the access completes, faults or times out.
module mem_access_controller #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input logic                     clk,
  input logic                     rst_n,
  mem_access_controller_if.master bus
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t             state_q, state_d;
  logic               memReq_q, memReq_d;
  logic               memWe_q, memWe_d;
  logic [31:0]        memAddr_q, memAddr_d;
  logic [31:0]        memWdata_q, memWdata_d;
  logic [31:0]        readData_q, readData_d;
  logic               fault_q, fault_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic access;
  logic aligned;

  assign access  = bus.EX_MEM_MemRead | bus.EX_MEM_MemWrite;
  assign aligned = (bus.EX_MEM_ALUResult[1:0] == 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      memReq_q   <= 1'b0;
      memWe_q    <= 1'b0;
      memAddr_q  <= '0;
      memWdata_q <= '0;
      readData_q <= '0;
      fault_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      memReq_q   <= memReq_d;
      memWe_q    <= memWe_d;
      memAddr_q  <= memAddr_d;
      memWdata_q <= memWdata_d;
      readData_q <= readData_d;
      fault_q    <= fault_d;
      cnt_q      <= cnt_d;
    end
  end

  // A store that also has MemRead set issues as a write, so mem_we follows MemWrite alone.
  always_comb begin
    state_d    = state_q;
    memReq_d   = memReq_q;
    memWe_d    = memWe_q;
    memAddr_d  = memAddr_q;
    memWdata_d = memWdata_q;
    readData_d = readData_q;
    fault_d    = fault_q;
    cnt_d      = cnt_q;

    case (state_q)
      IDLE: begin
        if (access) begin
          if (!aligned) begin
            state_d = DONE;
            fault_d = 1'b1;
          end else begin
            state_d    = WAIT;
            memReq_d   = 1'b1;
            memWe_d    = bus.EX_MEM_MemWrite;
            memAddr_d  = bus.EX_MEM_ALUResult;
            memWdata_d = bus.EX_MEM_RtData;
            cnt_d      = '0;
            fault_d    = 1'b0;
          end
        end
      end
      WAIT: begin
        if (bus.mem_ack) begin
          state_d  = DONE;
          memReq_d = 1'b0;
          if (!memWe_q) begin
            readData_d = bus.mem_rdata;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d  = DONE;
          memReq_d = 1'b0;
          fault_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.mem_req     = memReq_q;
  assign bus.mem_we      = memWe_q;
  assign bus.mem_addr    = memAddr_q;
  assign bus.mem_wdata   = memWdata_q;
  assign bus.MemReadData = readData_q;
  assign bus.mem_fault   = fault_q;
  assign bus.done        = (state_q == DONE);
  assign bus.stall       = ((state_q == IDLE) & access) | (state_q == WAIT);

endmodule

// File: doc/mem_access_controller.md
Name: mem_access_controller

Overview:
- Sequences data-memory accesses issued by the EX/MEM pipeline register toward a multi-cycle data memory that uses a req/ack handshake.
- Stalls the pipeline while an access is outstanding, holds request address and data stable, and captures read data.
- Flags misaligned and timed-out accesses.
- Sits between the EX/MEM register outputs and the data memory; its stall drives the IF/ID, ID/EX and EX/MEM hold enables.

Parameters:
- TIMEOUT, 16, max cycles WAIT holds mem_req without mem_ack before aborting (must be >=2)
- CNT_W, 5, width of wait counter (must satisfy 2^CNT_W > TIMEOUT)

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- EX_MEM_MemRead  input  1  load in EX/MEM stage
- EX_MEM_MemWrite  input  1  store in EX/MEM stage
- EX_MEM_ALUResult  input  32  byte address of access
- EX_MEM_RtData  input  32  store data
- mem_ack  input  1  memory completion, one-cycle pulse
- mem_rdata  input  32  memory read data, valid with mem_ack
- mem_req  output  1  request to memory, registered
- mem_we  output  1  1=write, 0=read, registered
- mem_addr  output  32  registered address
- mem_wdata  output  32  registered store data
- MemReadData  output  32  captured load data, registered
- stall  output  1  hold pipeline registers upstream of MEM/WB
- mem_fault  output  1  sticky-per-access fault, valid in DONE
- done  output  1  access completed this cycle (state DONE)

Behaviour:
- Reset (async, rst_n=0): state=IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, MemReadData=0, mem_fault=0, counter=0. Reset mid-WAIT drops mem_req immediately; the access is abandoned.
- access = EX_MEM_MemRead | EX_MEM_MemWrite. Both set: treated as write. MemReadData unchanged, no fault.
- stall is combinational: (state==IDLE & access) | (state==WAIT). In DONE, stall=0, so the pipeline advances exactly one instruction.
- done=1 only in DONE.
- States:
  - IDLE, access=0: remain; mem_req=0.
  - IDLE, access=1, ALUResult[1:0]!=0: go to DONE, set mem_fault=1, mem_req never asserted.
  - IDLE, access=1, aligned: go to WAIT; on that edge register mem_req=1, mem_we=MemWrite, mem_addr=ALUResult, mem_wdata=RtData, counter=0, mem_fault=0.
  - WAIT: mem_req, mem_we, mem_addr and mem_wdata are held stable.
    - mem_ack=1: go to DONE, mem_req<=0; if read, MemReadData<=mem_rdata.
    - Else if counter==TIMEOUT-1: go to DONE, mem_req<=0, mem_fault<=1, MemReadData unchanged.
    - Else counter<=counter+1 (saturation is impossible given the parameter rule).
    - Ack on the same cycle as the timeout limit: ack wins, no fault.
  - DONE: one cycle, then IDLE. mem_fault is held until the next access is accepted; it is cleared on IDLE->WAIT or on a new misaligned access.
- mem_ack outside WAIT is ignored and does not change MemReadData.
- Latency: aligned access whose ack arrives k cycles after mem_req rises (k>=1) gives stall high for k+1 cycles, then DONE.
  - Best case k=1: IDLE, WAIT, DONE = 2 stall cycles.
- Back-to-back accesses: the instruction arriving after DONE is evaluated in IDLE on the next cycle. No access is issued twice because DONE always releases stall for exactly one cycle.
- Width rules: addresses and data pass through at 32 bits unmodified; the counter is CNT_W bits unsigned.

Test Plan:
- Reset mid-operation:
  - Stimulus: assert rst_n=0 while in WAIT with mem_req=1.
  - Response: mem_req=0 without waiting for a clock edge; all outputs 0; state IDLE after release; stall=0 with access=0.
- Aligned load:
  - Stimulus: MemRead=1, ALUResult=0x00000010; mem_ack pulses 3 cycles after mem_req rises, mem_rdata=0xDEADBEEF.
  - Response: mem_addr=0x10, mem_we=0, stall high for 4 cycles; in DONE, MemReadData=0xDEADBEEF, done=1, mem_fault=0, stall=0.
- Aligned store:
  - Stimulus: MemWrite=1, ALUResult=0x20, RtData=0x12345678; ack after 1 cycle.
  - Response: mem_we=1, mem_wdata=0x12345678 held stable until ack; MemReadData unchanged.
- Misaligned access:
  - Stimulus: MemRead=1, ALUResult=0x00000013.
  - Response: mem_req never rises; next cycle done=1, mem_fault=1; stall high for exactly 1 cycle.
- Timeout (TIMEOUT=16):
  - Stimulus: no ack.
  - Response: mem_req high for 16 cycles, then DONE with mem_fault=1.
  - Variant: ack arriving on cycle 16 gives mem_fault=0 and the data is captured.
- Back-to-back and corner cases:
  - Stimulus: two consecutive loads.
  - Response: two separate request phases separated by DONE then IDLE.
  - Stimulus: MemRead=MemWrite=1.
  - Response: write issued (mem_we=1).
  - Stimulus: stray mem_ack in IDLE.
  - Response: ignored.
